// File: rtl/n8_pkg.sv
// -----------------------------------------------------------------------------
// n8_pkg
// Shared constants for the NES controller button-event block.
//   - Button index constants. They match the bit order of the driver's level
//     vector: bit7 right, 6 left, 5 down, 4 up, 3 start, 2 select, 1 b, 0 a.
//   - Event code layout: {kind, idx[2:0]}, where kind 1 = press, 0 = release.
// No ports (package).
// -----------------------------------------------------------------------------
package n8_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int   EVT_W       = 4;
  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  typedef logic [EVT_W-1:0] evt_t;

  // Pack one event code from its kind bit and button index.
  function automatic evt_t make_evt(input logic kind, input logic [2:0] idx);
    return {kind, idx};
  endfunction

endpackage

// File: rtl/n8_debounce_bit.sv
// -----------------------------------------------------------------------------
// n8_debounce_bit
// Conditions one button level from the driver's slow clock domain.
// Stages: a 2-flop synchroniser, a run-length debounce counter, the debounced
// state and registered one-cycle edge pulses.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   i_raw    in   raw button level (asynchronous to clk)
//   o_state  out  debounced level
//   o_rise   out  one-cycle pulse in the cycle o_state goes 0->1
//   o_fall   out  one-cycle pulse in the cycle o_state goes 1->0
// Parameters:
//   DEBOUNCE  number of consecutive cycles the synchronised level must differ
//             from o_state before o_state flips (>= 1)
//   DB_CNT_W  counter width, 2**DB_CNT_W > DEBOUNCE
// -----------------------------------------------------------------------------
module n8_debounce_bit #(
  parameter int DEBOUNCE = 500000,
  parameter int DB_CNT_W = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_state,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE - 1);

  logic                r_meta;
  logic                r_sync;
  logic                r_state;
  logic                r_rise;
  logic                r_fall;
  logic [DB_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_state <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sync != r_state) begin
        // The counter holds the number of earlier consecutive differing
        // cycles, so reaching CNT_LAST here means DEBOUNCE differing cycles.
        if (r_cnt == CNT_LAST) begin
          r_state <= r_sync;
          r_rise  <= r_sync;
          r_fall  <= ~r_sync;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_state = r_state;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/n8_button_events.sv
// -----------------------------------------------------------------------------
// n8_button_events
// Consumer of the 8-button NES controller driver. It synchronises and
// debounces each button, emits press/release pulses, and queues event codes
// {kind, idx} in a small FIFO with a valid/ready interface.
// Optional feature: define N8_AUTO_REPEAT_EN to add d-pad (bits 7:4) auto-repeat
// press events after REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   btn_in[7:0]    in   raw levels, 1 = pressed
//   btn_state[7:0] out  debounced levels
//   press_pulse    out  one-cycle pulse per bit on a btn_state rise
//   release_pulse  out  one-cycle pulse per bit on a btn_state fall
//   evt_valid      out  FIFO not empty
//   evt_data[3:0]  out  head entry {kind, idx}
//   evt_ready      in   pop head when evt_valid && evt_ready
//   ovf            out  sticky event-loss flag, cleared only by reset
// -----------------------------------------------------------------------------
module n8_button_events
  import n8_pkg::*;
#(
  parameter int DEBOUNCE      = 500000,
  parameter int DB_CNT_W      = 20,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       btn_in,
  output logic [7:0]       btn_state,
  output logic [7:0]       press_pulse,
  output logic [7:0]       release_pulse,
  output logic             evt_valid,
  output logic [EVT_W-1:0] evt_data,
  input  logic             evt_ready,
  output logic             ovf
);

  localparam int                PTR_W   = $clog2(FIFO_DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [7:0] w_state;
  logic [7:0] w_rise;
  logic [7:0] w_fall;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_db
      n8_debounce_bit #(
        .DEBOUNCE (DEBOUNCE),
        .DB_CNT_W (DB_CNT_W)
      ) u_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (btn_in[gi]),
        .o_state (w_state[gi]),
        .o_rise  (w_rise[gi]),
        .o_fall  (w_fall[gi])
      );
    end
  endgenerate

  assign btn_state     = w_state;
  assign press_pulse   = w_rise;
  assign release_pulse = w_fall;

  // ---------------------------------------------------------------------------
  // Auto-repeat source: a press request mask for held d-pad bits.
  // ---------------------------------------------------------------------------
  logic [7:0] w_rep_mask;

`ifdef N8_AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_phase;   // 0: waiting for first repeat, 1: periodic
  logic             w_dpad_chg;
  logic             w_dpad_held;
  logic             w_rep_fire;
  logic [REP_W-1:0] w_rep_last;

  assign w_dpad_chg  = |(w_rise[7:4] | w_fall[7:4]);
  assign w_dpad_held = |w_state[7:4];
  assign w_rep_last  = r_rep_phase ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
  // A d-pad edge in this cycle restarts the timing, so it never coincides with
  // a repeat on the same bit.
  assign w_rep_fire  = w_dpad_held && !w_dpad_chg && (r_rep_cnt == w_rep_last);
  assign w_rep_mask  = w_rep_fire ? {w_state[7:4], 4'b0000} : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_dpad_chg || !w_dpad_held) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_rep_fire) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b1;
    end else begin
      r_rep_cnt <= r_rep_cnt + 1'b1;
    end
  end
`else
  assign w_rep_mask = 8'h00;
`endif

  // ---------------------------------------------------------------------------
  // Pending masks and lowest-index push selection.
  // ---------------------------------------------------------------------------
  logic [7:0]       r_pend;
  logic [7:0]       r_pkind;
  logic [7:0]       w_pend_next;
  logic [7:0]       w_pkind_next;
  logic [7:0]       w_ev_set;
  logic [7:0]       w_ev_kind;
  logic             w_ovf_hit;
  logic             w_push_found;
  logic [2:0]       w_push_idx;
  logic             w_push;
  logic             w_pop;
  logic             w_room;
  evt_t             w_push_evt;

  logic [EVT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  assign w_ev_set  = w_rise | w_fall | w_rep_mask;
  assign w_ev_kind = w_rise | w_rep_mask;

  // Scan from the top so the lowest set index is the one left selected.
  always_comb begin
    w_push_found = 1'b0;
    w_push_idx   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (r_pend[k]) begin
        w_push_found = 1'b1;
        w_push_idx   = 3'(k);
      end
    end
  end

  assign w_pop      = (r_count != '0) && evt_ready;
  assign w_room     = (r_count < DEPTH_C) || w_pop;
  assign w_push     = w_push_found && w_room;
  assign w_push_evt = make_evt(r_pkind[w_push_idx], w_push_idx);

  always_comb begin
    w_pend_next  = r_pend;
    w_pkind_next = r_pkind;
    w_ovf_hit    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (w_push && (w_push_idx == 3'(k))) begin
        // The pushed entry leaves; a simultaneous new edge starts afresh.
        w_pend_next[k]  = w_ev_set[k];
        w_pkind_next[k] = w_ev_kind[k];
      end else if (w_ev_set[k]) begin
        if (!r_pend[k]) begin
          w_pend_next[k]  = 1'b1;
          w_pkind_next[k] = w_ev_kind[k];
        end else if (r_pkind[k] != w_ev_kind[k]) begin
          // Press and release cancel out; the pair is lost.
          w_pend_next[k] = 1'b0;
          w_ovf_hit      = 1'b1;
        end else begin
          // Same-kind event already waiting: drop the newer one.
          w_ovf_hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= 8'h00;
      r_pkind <= 8'h00;
      r_ovf   <= 1'b0;
    end else begin
      r_pend  <= w_pend_next;
      r_pkind <= w_pkind_next;
      r_ovf   <= r_ovf | w_ovf_hit;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO. Storage has no reset; only pointers and count are cleared.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_evt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign evt_valid = (r_count != '0);
  assign evt_data  = r_mem[r_rd_ptr];
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_n8_button_events.sv
module tb_n8_button_events;
  import n8_pkg::*;

  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam int RD    = 8;
  localparam int RP    = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] btn_in;
  logic [7:0] btn_state;
  logic [7:0] press_pulse;
  logic [7:0] release_pulse;
  logic       evt_valid;
  logic [3:0] evt_data;
  logic       evt_ready;
  logic       ovf;

  always #5 clk = ~clk;

  n8_button_events #(
    .DEBOUNCE      (D),
    .DB_CNT_W      (20),
    .FIFO_DEPTH    (DEPTH),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .btn_state     (btn_state),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .evt_valid     (evt_valid),
    .evt_data      (evt_data),
    .evt_ready     (evt_ready),
    .ovf           (ovf)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: history of synchronised samples, debounced state,
  // pending events and the event queue.
  logic [7:0] m_meta;
  logic [7:0] m_sync_hist [D];
  logic [7:0] m_state;
  logic [7:0] m_press;
  logic [7:0] m_release;
  logic [7:0] m_pend;
  logic [7:0] m_pkind;
  logic       m_ovf;
  logic [3:0] m_q [$];
  int         cyc = 0;
  int         m_dpad_chg_cyc = 0;

  int log_d [$];
  int log_c [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_meta    = 8'h00;
    for (int j = 0; j < D; j++) m_sync_hist[j] = 8'h00;
    m_state   = 8'h00;
    m_press   = 8'h00;
    m_release = 8'h00;
    m_pend    = 8'h00;
    m_pkind   = 8'h00;
    m_ovf     = 1'b0;
    m_q.delete();
    m_dpad_chg_cyc = cyc;
  endtask

  // One clock edge of the reference model, driven by pre-edge values.
  task automatic model_step();
    logic       pop;
    logic       room;
    int         pidx;
    logic [7:0] rep;
    logic [7:0] ev_set;
    logic [7:0] ev_kind;
    logic [7:0] new_state;
    logic       flip;
    pop  = (m_q.size() > 0) && evt_ready;
    room = (m_q.size() < DEPTH) || pop;
    rep  = 8'h00;
`ifdef N8_AUTO_REPEAT_EN
    begin
      int age;
      age = cyc - m_dpad_chg_cyc;
      if ((m_state[7:4] != 4'h0) && (age >= RD) && (((age - RD) % RP) == 0))
        rep = {m_state[7:4], 4'h0};
    end
`endif
    ev_set  = m_press | m_release | rep;
    ev_kind = m_press | rep;
    pidx = -1;
    for (int k = 0; k < 8; k++) if (m_pend[k] && pidx < 0) pidx = k;
    if (pop) begin
      log_d.push_back(int'(m_q[0]));
      log_c.push_back(cyc);
      $display("evt pop cycle %0d data %b", cyc, m_q[0]);
      void'(m_q.pop_front());
    end
    if (pidx >= 0 && room) begin
      m_q.push_back({m_pkind[pidx], 3'(pidx)});
      m_pend[pidx] = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      if (ev_set[k]) begin
        if (!m_pend[k]) begin
          m_pend[k]  = 1'b1;
          m_pkind[k] = ev_kind[k];
        end else if (m_pkind[k] != ev_kind[k]) begin
          m_pend[k] = 1'b0;
          m_ovf     = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    // A bit flips once its last D synchronised samples all disagree with it.
    new_state = m_state;
    for (int b = 0; b < 8; b++) begin
      flip = 1'b1;
      for (int j = 0; j < D; j++) if (m_sync_hist[j][b] == m_state[b]) flip = 1'b0;
      if (flip) new_state[b] = ~m_state[b];
    end
    m_press   = new_state & ~m_state;
    m_release = m_state & ~new_state;
    m_state   = new_state;
    for (int j = D - 1; j > 0; j--) m_sync_hist[j] = m_sync_hist[j-1];
    m_sync_hist[0] = m_meta;
    m_meta = btn_in;
    cyc++;
    if ((m_press[7:4] | m_release[7:4]) != 4'h0) m_dpad_chg_cyc = cyc;
  endtask

  task automatic check_all();
    chk("btn_state", btn_state, m_state);
    chk("press_pulse", press_pulse, m_press);
    chk("release_pulse", release_pulse, m_release);
    chk("evt_valid", evt_valid, m_q.size() > 0);
    chk("ovf", ovf, m_ovf);
    if (m_q.size() > 0) chk("evt_data", evt_data, m_q[0]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  function automatic int log_get(input int i, input logic is_cyc);
    if (i >= log_d.size()) return -1;
    return is_cyc ? log_c[i] : log_d[i];
  endfunction

  task automatic clear_log();
    log_d.delete();
    log_c.delete();
  endtask

  initial begin
    int n;
    int npress;
    logic found;

    // 1. Reset with all buttons high at the input.
    rst_n = 1'b0; btn_in = 8'hFF; evt_ready = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_btn_state", btn_state, 8'h00);
    chk("rst_evt_valid", evt_valid, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1; btn_in = 8'h00;
    repeat (12) tick();
    chk("idle_no_events", evt_valid, 1'b0);

    // 2. Press A: latency and one event.
    btn_in = 8'h01; n = 0; found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      if (btn_state[0]) begin found = 1'b1; n = i; end
    end
    chk("press_latency", n, 6);
    chk("press_pulse_a", press_pulse, 8'h01);
    tick();
    chk("press_pulse_1cyc", press_pulse, 8'h00);
    for (int i = 0; i < 10 && !evt_valid; i++) tick();
    chk("evt_a_valid", evt_valid, 1'b1);
    chk("evt_a_data", evt_data, 4'b1000);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;

    // 3. Glitch on up, 3 cycles.
    btn_in = 8'h11; repeat (3) tick();
    btn_in = 8'h01; repeat (10) tick();
    chk("glitch_state", btn_state, 8'h01);
    chk("glitch_no_evt", evt_valid, 1'b0);

    btn_in = 8'h00; evt_ready = 1'b1; repeat (12) tick();
    chk("release_a_drained", evt_valid, 1'b0);

    // 4. Simultaneous press of A and right, then release.
    clear_log();
    btn_in = 8'h81; repeat (12) tick();
    chk("sim_press_n", log_d.size(), 2);
    chk("sim_press_0", log_get(0, 1'b0), 4'b1000);
    chk("sim_press_1", log_get(1, 1'b0), 4'b1111);
    chk("sim_press_gap", log_get(1, 1'b1) - log_get(0, 1'b1), 1);
    clear_log();
    btn_in = 8'h00; repeat (12) tick();
    chk("sim_rel_n", log_d.size(), 2);
    chk("sim_rel_0", log_get(0, 1'b0), 4'b0000);
    chk("sim_rel_1", log_get(1, 1'b0), 4'b0111);

    // 5. Backpressure: five presses into a 4-entry FIFO.
    clear_log();
    evt_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      btn_in[k] = 1'b1;
      repeat (8) tick();
    end
    chk("bp_full_valid", evt_valid, 1'b1);
    chk("bp_no_ovf_yet", ovf, 1'b0);
    btn_in[4] = 1'b0;
    repeat (8) tick();
    chk("bp_ovf", ovf, 1'b1);
    evt_ready = 1'b1;
    repeat (8) tick();
    chk("bp_drain_n", log_d.size(), 4);
    chk("bp_drain_0", log_get(0, 1'b0), 4'b1000);
    chk("bp_drain_1", log_get(1, 1'b0), 4'b1001);
    chk("bp_drain_2", log_get(2, 1'b0), 4'b1010);
    chk("bp_drain_3", log_get(3, 1'b0), 4'b1011);
    btn_in = 8'h00; repeat (14) tick();

    // 6. Hold up for a while: repeats only when the feature is built in.
    clear_log();
    npress = 0;
    btn_in = 8'h10;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (press_pulse[4]) npress++;
    end
    chk("hold_up_pulses", npress, 1);
`ifdef N8_AUTO_REPEAT_EN
    chk("rep_n_ge4", log_d.size() >= 4, 1'b1);
    chk("rep_d0", log_get(0, 1'b0), 4'b1100);
    chk("rep_d1", log_get(1, 1'b0), 4'b1100);
    chk("rep_d3", log_get(3, 1'b0), 4'b1100);
    chk("rep_gap1", log_get(1, 1'b1) - log_get(0, 1'b1), 8);
    chk("rep_gap2", log_get(2, 1'b1) - log_get(1, 1'b1), 4);
    chk("rep_gap3", log_get(3, 1'b1) - log_get(2, 1'b1), 4);
`else
    chk("hold_up_n", log_d.size(), 1);
    chk("hold_up_d0", log_get(0, 1'b0), 4'b1100);
`endif
    btn_in = 8'h00; repeat (12) tick();

    // Randomised traffic with occasional mid-operation reset.
    for (int it = 0; it < 300; it++) begin
      int r;
      int hold;
      r = $urandom_range(0, 9);
      if (r < 2) btn_in = 8'($urandom);
      else if (r < 8) btn_in[$urandom_range(0, 7)] ^= 1'b1;
      hold = $urandom_range(1, 9);
      for (int h = 0; h < hold; h++) begin
        evt_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
